cpu_run_ctrl: RTL and testbench

Run/halt/single-step controller for the single-cycle RISC-V core. Sits between the board switches/buttons and the core, producing the clock enable that gates PC and register-file/memory updates. Also provides a PC breakpoint, halts on `ebreak`, and keeps a retired-instruction counter for the debug display.

---
 rtl/cpu_run_ctrl.sv | 140 ++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
//   Run/halt/single-step controller for the single-cycle RISC-V core.
//   It produces the core update enable (cpu_en) from the board run switch
//   and step button. It halts on a PC breakpoint or an ebreak instruction,
//   and it counts retired instructions for the debug display.
//
//   Build option:
//     CPU_RUN_CTRL_BP_EN  defined   -> PC breakpoint compare active
//                         undefined -> bp_en / bp_addr ignored, only ebreak
//                                      can cause BREAK
//
//   Parameters:
//     CNT_W       width of the retired-instruction counter
//
//   Ports:
//     clk         clock
//     reset       asynchronous, active-high reset
//     run         free-run request level (debounced, synchronous)
//     step        single-step button level (debounced, synchronous)
//     bp_en       breakpoint enable
//     bp_addr     breakpoint PC
//     PC_in       current core PC
//     inst_in     instruction fetched at PC_in
//     cpu_en      core update enable (combinational)
//     halted      1 in HALT or BREAK
//     state       HALT=0, RUN=1, STEP=2, BREAK=3
//     halt_cause  0=user/reset, 1=breakpoint, 2=ebreak
//     instret     number of cycles with cpu_en=1, wraps silently
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             step,
   input  logic             bp_en,
   input  logic [31:0]      bp_addr,
   input  logic [31:0]      PC_in,
   input  logic [31:0]      inst_in,
   output logic             cpu_en,
   output logic             halted,
   output logic [1:0]       state,
   output logic [1:0]       halt_cause,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [1:0] {
      S_HALT  = 2'd0,
      S_RUN   = 2'd1,
      S_STEP  = 2'd2,
      S_BREAK = 2'd3
   } state_t;

   localparam logic [1:0]  CAUSE_USER   = 2'd0;
   localparam logic [1:0]  CAUSE_BP     = 2'd1;
   localparam logic [1:0]  CAUSE_EBREAK = 2'd2;
   localparam logic [31:0] EBREAK_INSN  = 32'h0010_0073;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t st;
   logic   step_q;
   logic   step_rise;
   logic   hit_pc;
   logic   hit_ebreak;
   logic   hit;

   assign step_rise  = step & ~step_q;
   assign hit_ebreak = (inst_in == EBREAK_INSN);

`ifdef CPU_RUN_CTRL_BP_EN
   assign hit_pc = bp_en && (PC_in == bp_addr);
`else
   // Breakpoint compare is compiled out. The ports are kept so that the board
   // wrapper does not change, and they are folded into a sink here.
   logic bp_unused;
   assign bp_unused = ^{bp_en, bp_addr, PC_in};
   assign hit_pc    = 1'b0;
`endif

   assign hit = hit_pc | hit_ebreak;

   // The enable is combinational so that dropping run or reaching a
   // breakpoint stops the core in the same cycle. The hitting instruction is
   // never committed. STEP commits unconditionally, so a step can execute the
   // instruction sitting at a breakpoint or an ebreak.
   assign cpu_en = ((st == S_RUN) && run && !hit) || (st == S_STEP);
   assign halted = (st == S_HALT) || (st == S_BREAK);
   assign state  = st;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st         <= S_HALT;
         halt_cause <= CAUSE_USER;
         instret    <= '0;
         step_q     <= 1'b0;
      end else begin
         step_q <= step;
         if (cpu_en) begin
            instret <= instret + CNT_ONE;
         end
         case (st)
            // When run and a step edge arrive together, run wins.
            S_HALT: begin
               if (run) begin
                  st <= S_RUN;
               end else if (step_rise) begin
                  st <= S_STEP;
               end
            end
            S_STEP: begin
               st <= S_HALT;
            end
            // halt_cause is written only when leaving RUN. An ebreak takes
            // priority over a simultaneous PC match.
            S_RUN: begin
               if (!run) begin
                  st         <= S_HALT;
                  halt_cause <= CAUSE_USER;
               end else if (hit) begin
                  st         <= S_BREAK;
                  halt_cause <= hit_ebreak ? CAUSE_EBREAK : CAUSE_BP;
               end
            end
            // Leaving BREAK requires run to be dropped first. Step edges are
            // ignored while in BREAK.
            S_BREAK: begin
               if (!run) begin
                  st <= S_HALT;
               end
            end
            default: begin
               st <= S_HALT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

   localparam int CNT_W = 4;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   // Mode numbering follows the externally visible state encoding.
   localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2, M_BREAK = 3;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             run = 1'b0;
   logic             step = 1'b0;
   logic             bp_en = 1'b0;
   logic [31:0]      bp_addr = '0;
   logic [31:0]      PC_in = '0;
   logic [31:0]      inst_in = NOP;
   logic             cpu_en;
   logic             halted;
   logic [1:0]       state;
   logic [1:0]       halt_cause;
   logic [CNT_W-1:0] instret;

   cpu_run_ctrl #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .step       (step),
      .bp_en      (bp_en),
      .bp_addr    (bp_addr),
      .PC_in      (PC_in),
      .inst_in    (inst_in),
      .cpu_en     (cpu_en),
      .halted     (halted),
      .state      (state),
      .halt_cause (halt_cause),
      .instret    (instret)
   );

   always #5 clk = ~clk;

   typedef struct {
      int en;
      int st;
      int hl;
      int hc;
      int cnt;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model state.
   int m_mode  = M_HALT;
   int m_cause = 0;
   int m_cnt   = 0;
   int m_stepq = 0;
   logic [31:0] pc = '0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Monitor: the DUT presents a fresh set of outputs every cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("cpu_en",     int'(cpu_en),     e.en);
            check("state",      int'(state),      e.st);
            check("halted",     int'(halted),     e.hl);
            check("halt_cause", int'(halt_cause), e.hc);
            check("instret",    int'(instret),    e.cnt);
         end
      end
   end

   // One clock cycle of stimulus. Inputs change 2 time units after the rising
   // edge. The expected outputs for this cycle are queued, and then the model
   // advances across the next edge. The bench plays the core: the PC advances
   // by 4 on every committed instruction.
   task automatic cycle(input logic r, input logic s, input logic be,
                        input logic [31:0] ba, input logic [31:0] inst,
                        input logic rst);
      exp_t e;
      bit   pc_match, eb_match, en, rise;
      @(posedge clk);
      #2;
      reset = rst; run = r; step = s; bp_en = be; bp_addr = ba;
      inst_in = inst; PC_in = pc;
      if (rst) begin
         m_mode = M_HALT; m_cause = 0; m_cnt = 0; m_stepq = 0; pc = '0;
         e = '{0, M_HALT, 1, 0, 0};
         q.push_back(e);
         return;
      end
`ifdef CPU_RUN_CTRL_BP_EN
      pc_match = be && (pc == ba);
`else
      pc_match = 1'b0;
`endif
      eb_match = (inst == EBREAK);
      en = (m_mode == M_RUN && r && !(pc_match || eb_match)) || (m_mode == M_STEP);
      e.en  = int'(en);
      e.st  = m_mode;
      e.hl  = int'(m_mode == M_HALT || m_mode == M_BREAK);
      e.hc  = m_cause;
      e.cnt = m_cnt;
      q.push_back(e);
      rise    = s && (m_stepq == 0);
      m_stepq = int'(s);
      if (en) begin
         m_cnt = (m_cnt + 1) % (1 << CNT_W);
         pc    = pc + 32'd4;
      end
      case (m_mode)
         M_HALT:  m_mode = r ? M_RUN : (rise ? M_STEP : M_HALT);
         M_STEP:  m_mode = M_HALT;
         M_RUN: begin
            if (!r) begin
               m_mode = M_HALT; m_cause = 0;
            end else if (pc_match || eb_match) begin
               m_mode = M_BREAK; m_cause = eb_match ? 2 : 1;
            end
         end
         default: if (!r) m_mode = M_HALT;
      endcase
   endtask

   initial begin
      int n;
      // Reset, then idle with run low.
      repeat (2) cycle(0, 0, 0, 0, NOP, 1);
      repeat (10) cycle(0, 0, 0, 0, NOP, 0);

      // Held step: exactly one pulse.
      repeat (5) cycle(0, 1, 0, 0, NOP, 0);
      repeat (3) cycle(0, 0, 0, 0, NOP, 0);

      // Free-run 20 cycles (counter wraps at CNT_W=4), then stop.
      repeat (20) cycle(1, 0, 0, 0, NOP, 0);
      repeat (3) cycle(0, 0, 0, 0, NOP, 0);

      // Breakpoint at 0x10, running from PC 0.
      cycle(0, 0, 0, 0, NOP, 1);
      repeat (8) cycle(1, 0, 1, 32'h10, NOP, 0);
      cycle(1, 1, 1, 32'h10, NOP, 0);          // step ignored in BREAK/RUN
      repeat (2) cycle(0, 0, 1, 32'h10, NOP, 0);
      cycle(0, 1, 1, 32'h10, NOP, 0);          // step executes the bp PC
      repeat (3) cycle(0, 0, 1, 32'h10, NOP, 0);

      // ebreak while running, also with a PC match at the same time.
      repeat (3) cycle(1, 0, 0, 0, NOP, 0);
      repeat (3) cycle(1, 0, 0, 0, EBREAK, 0);
      repeat (2) cycle(0, 0, 0, 0, EBREAK, 0);
      cycle(0, 1, 0, 0, EBREAK, 0);            // step executes the ebreak
      repeat (2) cycle(0, 0, 0, 0, NOP, 0);
      cycle(1, 0, 1, pc, EBREAK, 0);
      repeat (2) cycle(1, 0, 1, pc, EBREAK, 0);
      repeat (2) cycle(0, 0, 0, 0, NOP, 0);

      // run and step edge together: run wins.
      cycle(1, 1, 0, 0, NOP, 0);
      repeat (3) cycle(1, 1, 0, 0, NOP, 0);
      repeat (2) cycle(0, 0, 0, 0, NOP, 0);

      // Randomized section.
      for (int i = 0; i < 400; i++) begin
         logic        r, s, be, rs;
         logic [31:0] ba, in;
         r  = ($urandom_range(0, 3) != 0);
         s  = $urandom_range(0, 1);
         be = $urandom_range(0, 1);
         ba = pc + 32'(4 * $urandom_range(0, 3));
         in = ($urandom_range(0, 7) == 0) ? EBREAK : NOP;
         rs = ($urandom_range(0, 60) == 0);
         cycle(r, s, be, ba, in, rs);
      end

      // Wrap while free-running, then reset asserted mid-RUN.
      cycle(0, 0, 0, 0, NOP, 1);
      repeat (2) cycle(0, 0, 0, 0, NOP, 0);
      repeat (18) cycle(1, 0, 0, 0, NOP, 0);
      repeat (2) cycle(1, 0, 0, 0, NOP, 1);
      repeat (3) cycle(0, 0, 0, 0, NOP, 0);

      // Bounded drain of the scoreboard.
      n = 0;
      while (q.size() > 0 && n < 10) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
